// File: rtl/sub16_pkg.sv
// -----------------------------------------------------------------------------
// sub16_pkg
// Shared constants and types for the nibble-serial 16-bit subtractor.
//   WIDTH / NIB / NUM_NIB : datapath width, slice width, slices per operation
//   state_t               : controller states IDLE, CALC, DONE
//   flags_t               : result flags {sign, zero, borrow, parity, overflow}
//   FLAGS_RST             : flag values that correspond to Z == 0 after reset
// -----------------------------------------------------------------------------
package sub16_pkg;

  localparam int WIDTH   = 16;
  localparam int NIB     = 4;
  localparam int NUM_NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic sign;
    logic zero;
    logic borrow;
    logic parity;
    logic overflow;
  } flags_t;

  // Z == 0: not negative, zero, no borrow, even parity, no overflow
  localparam flags_t FLAGS_RST = '{sign: 1'b0, zero: 1'b1, borrow: 1'b0,
                                   parity: 1'b1, overflow: 1'b0};

endpackage

// File: rtl/sub16_serial_sub4.sv
// -----------------------------------------------------------------------------
// sub4
// Combinational 4-bit subtract slice: {o_bout, o_d} = i_x - i_y - i_bin.
// Ports:
//   i_x, i_y : 4-bit minuend / subtrahend nibbles
//   i_bin    : borrow in from the lower nibble
//   o_d      : 4-bit difference
//   o_bout   : borrow out to the next nibble
// -----------------------------------------------------------------------------
module sub4 (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout
);

  logic [4:0] w_diff;

  // Range of the true difference is -16..15, so bit 4 of the 5-bit
  // wrap-around result is set exactly when the difference went negative.
  assign w_diff = {1'b0, i_x} - {1'b0, i_y} - {4'b0000, i_bin};
  assign o_d    = w_diff[3:0];
  assign o_bout = w_diff[4];

endmodule

// File: rtl/sub16_serial.sv
// -----------------------------------------------------------------------------
// sub16_serial
// Nibble-serial 16-bit subtractor, Z = X - Y mod 2^16, one 4-bit slice per
// clock, LSB nibble first, with a valid/ready handshake on both sides.
// Optional feature macro: SUB16_SERIAL_ADD_MODE_EN adds input `op`
// (1 = add, 0 = subtract), latched together with X and Y.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   X, Y                : 16-bit operands
//   op                  : add/subtract select (only with the macro defined)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   Z                   : 16-bit result
//   sign, zero, borrow, parity, overflow : result flags
// -----------------------------------------------------------------------------
module sub16_serial
  import sub16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] X,
  input  logic [15:0] Y,
`ifdef SUB16_SERIAL_ADD_MODE_EN
  input  logic        op,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Z,
  output logic        sign,
  output logic        zero,
  output logic        borrow,
  output logic        parity,
  output logic        overflow
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_z;
  logic [1:0]         r_cnt;
  logic               r_bin;
  flags_t             r_flags;

  logic [NIB-1:0]     w_xn;
  logic [NIB-1:0]     w_yn;
  logic [NIB-1:0]     w_dn;
  logic               w_bout;
  logic               w_add;
  logic [WIDTH-1:0]   w_z_final;
  flags_t             w_flags_final;

`ifdef SUB16_SERIAL_ADD_MODE_EN
  logic               r_op;
  assign w_add = r_op;
`else
  assign w_add = 1'b0;
`endif

  // Current slice operands selected by the nibble counter.
  assign w_xn = r_x[r_cnt*NIB +: NIB];
  assign w_yn = r_y[r_cnt*NIB +: NIB];

  sub4 u_sub4 (
    .i_x    (w_xn),
    .i_y    (w_yn),
    .i_bin  (r_bin),
    .o_d    (w_dn),
    .o_bout (w_bout)
  );

  // Full result as it will look after the last slice is written.
  assign w_z_final = {w_dn, r_z[WIDTH-NIB-1:0]};

  // In add mode r_y holds ~Y and the chain starts with borrow 1, so
  // X - ~Y - 1 == X + Y; the final borrow is the inverted carry. The
  // subtract overflow formula on ~Y equals the add overflow formula on Y.
  always_comb begin
    w_flags_final.sign     = w_dn[NIB-1];
    w_flags_final.zero     = (w_z_final == '0);
    w_flags_final.borrow   = w_bout ^ w_add;
    w_flags_final.parity   = ~^w_z_final;
    w_flags_final.overflow = ( r_x[WIDTH-1] & ~r_y[WIDTH-1] & ~w_dn[NIB-1]) |
                             (~r_x[WIDTH-1] &  r_y[WIDTH-1] &  w_dn[NIB-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= 2'd0;
      r_bin   <= 1'b0;
      r_flags <= FLAGS_RST;
`ifdef SUB16_SERIAL_ADD_MODE_EN
      r_op    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= X;
            r_cnt <= 2'd0;
`ifdef SUB16_SERIAL_ADD_MODE_EN
            r_op  <= op;
            r_y   <= op ? ~Y : Y;
            r_bin <= op;
`else
            r_y   <= Y;
            r_bin <= 1'b0;
`endif
            r_state <= CALC;
          end
        end
        CALC: begin
          r_z[r_cnt*NIB +: NIB] <= w_dn;
          r_bin <= w_bout;
          r_cnt <= r_cnt + 2'd1;
          // Flags only change on the last slice so they never show
          // partial-result values while the chain is running.
          if (r_cnt == 2'd3) begin
            r_flags <= w_flags_final;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Z         = r_z;
  assign sign      = r_flags.sign;
  assign zero      = r_flags.zero;
  assign borrow    = r_flags.borrow;
  assign parity    = r_flags.parity;
  assign overflow  = r_flags.overflow;

endmodule

// File: tb/tb_sub16_serial.sv
// -----------------------------------------------------------------------------
// tb_sub16_serial
// Directed self-checking bench for sub16_serial (default build, subtract only).
// Flags are compared as the vector {sign, zero, borrow, parity, overflow}.
// -----------------------------------------------------------------------------
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Z;
  logic        sign, zero, borrow, parity, overflow;

  int checks   = 0;
  int failures = 0;

  sub16_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .sign      (sign),
    .zero      (zero),
    .borrow    (borrow),
    .parity    (parity),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags_now();
    return {sign, zero, borrow, parity, overflow};
  endfunction

  // Present operands, accept on the next edge, scramble the inputs, then
  // count edges until out_valid (bounded). Leaves us #1 after an edge.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, output int lat);
    @(negedge clk);
    X = xv; Y = yv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = ~xv; Y = xv ^ 16'h5A5A;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = 16'hAAAA; Y = 16'h5555;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (Z !== 16'h0000) begin failures++; $display("FAIL reset_z got=%h exp=0000", Z); end
    checks++; if (flags_now() !== 5'b01010) begin failures++; $display("FAIL reset_flags got=%b exp=01010", flags_now()); end
    @(negedge clk); rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b Z=%h flags=%b", in_ready, out_valid, Z, flags_now());
  endtask

  task automatic test_vectors();
    logic [15:0] tx [4] = '{16'h0005, 16'h0003, 16'h8000, 16'h1234};
    logic [15:0] ty [4] = '{16'h0003, 16'h0005, 16'h0001, 16'h1234};
    logic [15:0] tz [4] = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h0000};
    logic [4:0]  tf [4] = '{5'b00000, 5'b10100, 5'b00001, 5'b01010};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(tx[i], ty[i], lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat); end
      checks++; if (Z !== tz[i]) begin failures++; $display("FAIL vec%0d_z got=%h exp=%h", i, Z, tz[i]); end
      checks++; if (flags_now() !== tf[i]) begin failures++; $display("FAIL vec%0d_flags got=%b exp=%b", i, flags_now(), tf[i]); end
      handshake();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_idle got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid); end
      $display("vec%0d: X=%h Y=%h Z=%h flags=%b latency=%0d", i, tx[i], ty[i], Z, flags_now(), lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    run_op(16'h0100, 16'h0200, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL stall_latency got=%0d exp=4", lat); end
    // Next operands already waiting while the consumer stalls.
    X = 16'h7FFF; Y = 16'hFFFF; in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (Z !== 16'hFF00 || flags_now() !== 5'b10110 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0 (Z=%h flags=%b)", bad, Z, flags_now()); end
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_next_accept got in_ready=%b exp=0", in_ready); end
    in_valid = 1'b0; X = 16'h1111; Y = 16'h2222;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL stall2_latency got=%0d exp=4", lat); end
    checks++; if (Z !== 16'h8000) begin failures++; $display("FAIL stall2_z got=%h exp=8000", Z); end
    checks++; if (flags_now() !== 5'b10101) begin failures++; $display("FAIL stall2_flags got=%b exp=10101", flags_now()); end
    handshake();
    $display("stall: second result Z=%h flags=%b latency=%0d", Z, flags_now(), lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    @(negedge clk);
    X = 16'h0005; Y = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;           // accept
    in_valid = 1'b0;
    @(posedge clk); #1;           // first CALC edge, now in second CALC cycle
    rst = 1'b1;
    #2;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    checks++; if (Z !== 16'h0000) begin failures++; $display("FAIL abort_z got=%h exp=0000", Z); end
    checks++; if (flags_now() !== 5'b01010) begin failures++; $display("FAIL abort_flags got=%b exp=01010", flags_now()); end
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_valid got=%0d valid cycles exp=0", seen); end
    run_op(16'hFFFF, 16'h0001, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
    checks++; if (Z !== 16'hFFFE) begin failures++; $display("FAIL abort_next_z got=%h exp=FFFE", Z); end
    checks++; if (flags_now() !== 5'b10000) begin failures++; $display("FAIL abort_next_flags got=%b exp=10000", flags_now()); end
    handshake();
    $display("abort: recovery Z=%h flags=%b latency=%0d", Z, flags_now(), lat);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
